// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point add/subtract (align -> add/sub -> normalise/round)
// with RNE or truncate rounding, special values, status flags and valid/ready back-pressure.
module fp_addsub_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 15,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int SIG_W = MAN_W + 4;  // {hidden, man, guard, round, sticky}
  localparam int EXS_W = EXP_W + 2;  // signed exponent with carry and borrow headroom
  localparam int LZ_W  = $clog2(SIG_W);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(MAN_W + 2);

  typedef enum logic [1:0] {SP_NONE, SP_ILLEGAL, SP_NAN, SP_INF} special_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig_hi;
    logic [SIG_W-1:0] sig_lo;
    logic             eff_sub;
    special_e         special;
    logic             sp_sign;
    logic             trunc;
  } s1_t;

  typedef struct packed {
    logic                    sign;
    logic signed [EXS_W-1:0] exp;
    logic [SIG_W-1:0]        mag;
    special_e                special;
    logic                    sp_sign;
    logic                    trunc;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic s1_v, s2_v, s3_v;
  logic s1_free, s2_free, s3_free;

  // A stage may load when it is empty or its content moves downstream this cycle.
  assign s3_free   = !s3_v || out_ready;
  assign s2_free   = !s2_v || s3_free;
  assign s1_free   = !s1_v || s2_free;
  assign in_ready  = s1_free || flush_i;
  assign out_valid = s3_v;

  // ---------------- S1: unpack, swap, align ----------------
  logic             sign_a, sign_b, a_inf, b_inf, a_big;
  logic [EXP_W-1:0] exp_a, exp_b, exp_diff;
  logic [MAN_W:0]   sig_a, sig_b, sig_small;
  logic [SIG_W-1:0] lo_full, lo_lost, lo_aligned;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    sign_a     = a[WIDTH-1];
    sign_b     = b[WIDTH-1] ^ opcode[0];
    exp_a      = a[WIDTH-2:MAN_W];
    exp_b      = b[WIDTH-2:MAN_W];
    a_inf      = (exp_a == EXP_ONES);
    b_inf      = (exp_b == EXP_ONES);
    sig_a      = (exp_a == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
    sig_b      = (exp_b == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
    a_big      = {exp_a, sig_a} >= {exp_b, sig_b};
    exp_diff   = a_big ? exp_a - exp_b : exp_b - exp_a;
    sig_small  = a_big ? sig_b : sig_a;
    lo_full    = {sig_small, 3'b000};
    lo_lost    = '0;
    lo_aligned = '0;
    if (exp_diff > ALIGN_LIM) begin
      lo_aligned = {{(SIG_W-1){1'b0}}, |sig_small};
    end else begin
      lo_lost    = lo_full & ((SIG_W'(1) << exp_diff) - SIG_W'(1));
      lo_aligned = (lo_full >> exp_diff) | {{(SIG_W-1){1'b0}}, |lo_lost};
    end

    s1_d         = '0;
    s1_d.sign    = a_big ? sign_a : sign_b;
    s1_d.exp     = a_big ? exp_a : exp_b;
    s1_d.sig_hi  = {(a_big ? sig_a : sig_b), 3'b000};
    s1_d.sig_lo  = lo_aligned;
    s1_d.eff_sub = sign_a ^ sign_b;
    s1_d.trunc   = opcode[1];
    s1_d.special = SP_NONE;
    s1_d.sp_sign = 1'b0;
    if (opcode[3:2] != 2'b00) begin
      s1_d.special = SP_ILLEGAL;
    end else if (a_inf && b_inf && (sign_a != sign_b)) begin
      s1_d.special = SP_NAN;
    end else if (a_inf) begin
      s1_d.special = SP_INF;
      s1_d.sp_sign = sign_a;
    end else if (b_inf) begin
      s1_d.special = SP_INF;
      s1_d.sp_sign = sign_b;
    end
  end

  // ---------------- S2: add / subtract magnitudes ----------------
  logic [SIG_W:0] sum;

  always_comb begin
    sum  = s1_q.eff_sub ? ({1'b0, s1_q.sig_hi} - {1'b0, s1_q.sig_lo})
                        : ({1'b0, s1_q.sig_hi} + {1'b0, s1_q.sig_lo});
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.special = s1_q.special;
    s2_d.sp_sign = s1_q.sp_sign;
    s2_d.trunc   = s1_q.trunc;
    s2_d.exp     = $signed({2'b00, s1_q.exp});
    s2_d.mag     = sum[SIG_W-1:0];
    if (sum[SIG_W]) begin
      s2_d.mag = sum[SIG_W:1] | {{(SIG_W-1){1'b0}}, sum[0]};
      s2_d.exp = $signed({2'b00, s1_q.exp}) + EXS_W'(1);
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZ_W-1:0]         lz;
  logic [SIG_W-1:0]        norm;
  logic signed [EXS_W-1:0] exp_n, exp_r;
  logic [MAN_W-1:0]        mant_r;
  logic                    round_up, rnd_carry;
  logic [WIDTH-1:0]        res_d;
  logic [3:0]              flg_d;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SIG_W; i++) begin
      if (s2_q.mag[i]) lz = LZ_W'(SIG_W - 1 - i);
    end
    norm     = s2_q.mag << lz;
    exp_n    = s2_q.exp - $signed({{(EXS_W-LZ_W){1'b0}}, lz});
    round_up = !s2_q.trunc && norm[2] && (norm[1] || norm[0] || norm[3]);
    {rnd_carry, mant_r} = {1'b0, norm[SIG_W-2:3]} + {{MAN_W{1'b0}}, round_up};
    exp_r    = exp_n + $signed({{(EXS_W-1){1'b0}}, rnd_carry});

    res_d = '0;
    flg_d = '0;
    unique case (s2_q.special)
      SP_ILLEGAL: flg_d[3] = 1'b1;
      SP_NAN: begin
        res_d    = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        flg_d[2] = 1'b1;
      end
      SP_INF: res_d = {s2_q.sp_sign, EXP_ONES, {MAN_W{1'b0}}};
      default: begin
        if (!norm[SIG_W-1]) begin
          res_d = '0;  // exact cancellation is always +0
        end else if (exp_r >= $signed({2'b00, EXP_ONES})) begin
          res_d    = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
          flg_d[1] = 1'b1;
        end else if (exp_r[EXS_W-1] || exp_r == '0) begin
          res_d    = {s2_q.sign, {(WIDTH-1){1'b0}}};
          flg_d[0] = 1'b1;
        end else begin
          res_d = {s2_q.sign, exp_r[EXP_W-1:0], mant_r};
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      if (s1_free) s1_v <= in_valid;
      if (s2_free) s2_v <= s1_v;
      if (s3_free) s3_v <= s2_v;
    end
  end

  // NOTE: pipeline payload registers need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (s1_free && in_valid) s1_q <= s1_d;
    if (s2_free && s1_v)     s2_q <= s2_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else if (!flush_i && s3_free && s2_v) begin
      result <= res_d;
      flags  <= flg_d;
    end
  end
endmodule
